// File: rtl/instruction_memory_loader_if.sv
// Loader-side bundle: program byte stream, load control, core fetch path and instruction memory write port.
interface instruction_memory_loader_if #(
   parameter int unsigned ADDRESS_WIDTH = 12
);
   logic                     load_start;
   logic [ADDRESS_WIDTH-1:0] load_base_address;
   logic [ADDRESS_WIDTH:0]   load_word_count;
   logic                     byte_valid;
   logic [7:0]               byte_data;
   logic                     byte_ready;
   logic [31:0]              core_fetch_address;
   logic                     core_stall;
   logic                     instruction_memory_write_enable;
   logic [31:0]              instruction_memory_access_address;
   logic [31:0]              instruction_memory_write_data;
   logic                     load_busy;
   logic                     load_done;
   logic                     load_error;

   modport master (
      output load_start, load_base_address, load_word_count, byte_valid, byte_data,
             core_fetch_address,
      input  byte_ready, core_stall, instruction_memory_write_enable,
             instruction_memory_access_address, instruction_memory_write_data,
             load_busy, load_done, load_error
   );

   modport slave (
      input  load_start, load_base_address, load_word_count, byte_valid, byte_data,
             core_fetch_address,
      output byte_ready, core_stall, instruction_memory_write_enable,
             instruction_memory_access_address, instruction_memory_write_data,
             load_busy, load_done, load_error
   );
endinterface

// File: rtl/instruction_memory_loader.sv
// Loads a program from a byte stream into instruction memory, packing 4 bytes per word little-endian,
// while stalling the core; when idle the core fetch address passes straight through.
module instruction_memory_loader #(
   parameter int unsigned ADDRESS_WIDTH  = 12,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input logic                        clk,
   input logic                        reset,
   instruction_memory_loader_if.slave bus
);
   localparam int unsigned AW = ADDRESS_WIDTH;
   localparam int unsigned CW = ADDRESS_WIDTH + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ASSEMBLE,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   base_q, base_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   word_idx_q, word_idx_d;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic [TW-1:0]   timeout_q, timeout_d;
   logic [23:0]     asm_q, asm_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [AW-1:0]   waddr_q, waddr_d;

   logic byte_ready_q;
   logic core_stall_q;
   logic write_enable_q;
   logic load_busy_q;
   logic load_done_q;
   logic load_error_q;

   // Next-state and datapath updates; the top byte goes straight into the write word.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      timeout_d  = timeout_q;
      asm_d      = asm_q;
      wdata_d    = wdata_q;
      waddr_d    = waddr_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.load_start) begin
               base_d     = bus.load_base_address;
               count_d    = bus.load_word_count;
               word_idx_d = '0;
               byte_idx_d = '0;
               timeout_d  = '0;
               asm_d      = '0;
               state_d    = (bus.load_word_count == '0) ? S_DONE : S_ASSEMBLE;
            end
         end
         S_ASSEMBLE: begin
            if (bus.byte_valid && byte_ready_q) begin
               timeout_d  = '0;
               byte_idx_d = byte_idx_q + 2'd1;
               unique case (byte_idx_q)
                  2'd0: asm_d[7:0]   = bus.byte_data;
                  2'd1: asm_d[15:8]  = bus.byte_data;
                  2'd2: asm_d[23:16] = bus.byte_data;
                  default: begin
                     wdata_d = {bus.byte_data, asm_q};
                     waddr_d = base_q + word_idx_q[AW-1:0];
                     state_d = S_WRITE;
                  end
               endcase
            end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
               timeout_d  = '0;
               byte_idx_d = '0;
               asm_d      = '0;
               state_d    = S_ERROR;
            end else begin
               timeout_d = timeout_q + TW'(1);
            end
         end
         S_WRITE: begin
            timeout_d = '0;
            if (word_idx_q == count_q - CW'(1)) begin
               state_d = S_DONE;
            end else begin
               word_idx_d = word_idx_q + CW'(1);
               state_d    = S_ASSEMBLE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs decoded from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         base_q         <= '0;
         count_q        <= '0;
         word_idx_q     <= '0;
         byte_idx_q     <= '0;
         timeout_q      <= '0;
         asm_q          <= '0;
         wdata_q        <= '0;
         waddr_q        <= '0;
         byte_ready_q   <= 1'b0;
         core_stall_q   <= 1'b0;
         write_enable_q <= 1'b0;
         load_busy_q    <= 1'b0;
         load_done_q    <= 1'b0;
         load_error_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         base_q         <= base_d;
         count_q        <= count_d;
         word_idx_q     <= word_idx_d;
         byte_idx_q     <= byte_idx_d;
         timeout_q      <= timeout_d;
         asm_q          <= asm_d;
         wdata_q        <= wdata_d;
         waddr_q        <= waddr_d;
         byte_ready_q   <= (state_d == S_ASSEMBLE);
         core_stall_q   <= (state_d != S_IDLE);
         write_enable_q <= (state_d == S_WRITE);
         load_busy_q    <= (state_d != S_IDLE);
         load_done_q    <= (state_d == S_DONE);
         load_error_q   <= (state_d == S_ERROR);
      end
   end

   assign bus.byte_ready                        = byte_ready_q;
   assign bus.core_stall                        = core_stall_q;
   assign bus.instruction_memory_write_enable   = write_enable_q;
   assign bus.instruction_memory_write_data     = wdata_q;
   assign bus.load_busy                         = load_busy_q;
   assign bus.load_done                         = load_done_q;
   assign bus.load_error                        = load_error_q;
   // Core owns the address only while idle.
   assign bus.instruction_memory_access_address =
      (state_q == S_IDLE) ? bus.core_fetch_address : 32'(waddr_q);
endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: byte-queue reference model checked every cycle,
// plus hand-computed write addresses, data and pulse timing.
module tb_instruction_memory_loader;
   localparam int AW      = 12;
   localparam int TIMEOUT = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instruction_memory_loader_if #(.ADDRESS_WIDTH(AW)) bus ();

   instruction_memory_loader #(
      .ADDRESS_WIDTH (AW),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // reference model state
   bit           m_busy, m_ready, m_we, m_done, m_err;
   int           m_base, m_count, m_words, m_idle, m_addr;
   logic [31:0]  m_data;
   logic [7:0]   m_bytes[$];

   // observed event log
   logic [31:0]  w_addr[$];
   logic [31:0]  w_data[$];
   int           w_cyc[$];
   int           n_done, n_err, done_cyc, err_cyc, last_acc_cyc;

   logic [7:0]   blist[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s cyc=%0d wait bound expired", name, cyc);
   endtask

   task automatic m_clear();
      m_busy = 0; m_ready = 0; m_we = 0; m_done = 0; m_err = 0;
      m_words = 0; m_idle = 0;
      m_bytes.delete();
   endtask

   task automatic clear_log();
      w_addr.delete(); w_data.delete(); w_cyc.delete();
      n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1;
   endtask

   // One clock edge of the loader as seen from outside: bytes pile into a queue, four make a word.
   task automatic model_edge();
      if (reset) begin
         m_clear();
      end else if (m_done || m_err) begin
         m_done = 0; m_err = 0; m_busy = 0;
      end else if (m_we) begin
         m_we = 0;
         if (m_words == m_count) m_done = 1;
         else m_ready = 1;
      end else if (m_ready) begin
         if (bus.byte_valid) begin
            m_bytes.push_back(bus.byte_data);
            m_idle = 0;
            if (m_bytes.size() == 4) begin
               m_ready = 0;
               m_we    = 1;
               m_data  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
               m_addr  = (m_base + m_words) % (1 << AW);
               m_words++;
               m_bytes.delete();
            end
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               m_ready = 0;
               m_err   = 1;
               m_bytes.delete();
            end
         end
      end else if (bus.load_start) begin
         m_busy  = 1;
         m_base  = int'(bus.load_base_address);
         m_count = int'(bus.load_word_count);
         m_words = 0;
         m_idle  = 0;
         if (m_count == 0) m_done = 1;
         else m_ready = 1;
      end
   endtask

   task automatic monitor();
      chk("byte_ready", 32'(bus.byte_ready), 32'(m_ready));
      chk("core_stall", 32'(bus.core_stall), 32'(m_busy));
      chk("load_busy", 32'(bus.load_busy), 32'(m_busy));
      chk("write_enable", 32'(bus.instruction_memory_write_enable), 32'(m_we));
      chk("load_done", 32'(bus.load_done), 32'(m_done));
      chk("load_error", 32'(bus.load_error), 32'(m_err));
      if (!m_busy)
         chk("passthru_addr", bus.instruction_memory_access_address, bus.core_fetch_address);
      if (m_we) begin
         chk("write_addr", bus.instruction_memory_access_address, 32'(m_addr));
         chk("write_data", bus.instruction_memory_write_data, m_data);
      end
      if (bus.instruction_memory_write_enable === 1'b1) begin
         w_addr.push_back(bus.instruction_memory_access_address);
         w_data.push_back(bus.instruction_memory_write_data);
         w_cyc.push_back(cyc);
      end
      if (bus.load_done === 1'b1) begin n_done++; done_cyc = cyc; end
      if (bus.load_error === 1'b1) begin n_err++; err_cyc = cyc; end
   endtask

   // Inputs change at the falling edge; outputs are checked at the next falling edge.
   task automatic step();
      bus.core_fetch_address = $urandom;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      monitor();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic start_load(input int base, input int count);
      bus.load_base_address = AW'(base);
      bus.load_word_count   = (AW + 1)'(count);
      bus.load_start        = 1'b1;
      step();
      bus.load_start        = 1'b0;
   endtask

   task automatic send_bytes(input int first, input int n, input bit toggle);
      for (int i = first; i < first + n; i++) begin
         bit acc = 0;
         int tries = 0;
         while (!acc && tries < 20) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = blist[i];
            acc = bus.byte_ready;
            step();
            tries++;
         end
         bus.byte_valid = 1'b0;
         if (!acc) bound_fail("send_byte");
         last_acc_cyc = cyc;
         if (toggle && i != first + n - 1) step();
      end
   endtask

   task automatic wait_idle();
      int budget = 0;
      while (bus.load_busy !== 1'b0 && budget < 50) begin step(); budget++; end
      if (budget == 50) bound_fail("wait_idle");
   endtask

   initial begin
      int s;
      reset                 = 1'b1;
      bus.load_start        = 1'b0;
      bus.load_base_address = '0;
      bus.load_word_count   = '0;
      bus.byte_valid        = 1'b0;
      bus.byte_data         = '0;
      bus.core_fetch_address = '0;
      m_clear();
      clear_log();

      // reset state
      step();
      chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      chk("rst_core_stall", 32'(bus.core_stall), 32'd0);
      chk("rst_write_enable", 32'(bus.instruction_memory_write_enable), 32'd0);
      chk("rst_write_data", bus.instruction_memory_write_data, 32'd0);
      chk("rst_load_busy", 32'(bus.load_busy), 32'd0);
      reset = 1'b0;
      run(2);

      // case 1: two words from base 0x010, bytes every cycle
      clear_log();
      blist = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      start_load(32'h010, 2);
      s = cyc;
      send_bytes(0, 8, 1'b0);
      run(2);
      chk("c1_nwrites", 32'(w_addr.size()), 32'd2);
      if (w_addr.size() == 2) begin
         chk("c1_addr0", w_addr[0], 32'h010);
         chk("c1_data0", w_data[0], 32'h0000_0013);
         chk("c1_addr1", w_addr[1], 32'h011);
         chk("c1_data1", w_data[1], 32'h0010_0093);
         chk("c1_wcyc0", 32'(w_cyc[0]), 32'(s + 4));
         chk("c1_wcyc1", 32'(w_cyc[1]), 32'(s + 9));
      end
      chk("c1_done_cyc", 32'(done_cyc), 32'(s + 10));
      chk("c1_stall_after", 32'(bus.core_stall), 32'd0);
      wait_idle();

      // case 2: zero-word load
      clear_log();
      start_load(32'h020, 0);
      s = cyc;
      run(2);
      chk("c2_done_cyc", 32'(done_cyc), 32'(s));
      chk("c2_ndone", 32'(n_done), 32'd1);
      chk("c2_nwrites", 32'(w_addr.size()), 32'd0);

      // case 3: address wrap at top of memory
      clear_log();
      blist = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      start_load(32'hFFF, 2);
      send_bytes(0, 8, 1'b0);
      run(2);
      chk("c3_nwrites", 32'(w_addr.size()), 32'd2);
      if (w_addr.size() == 2) begin
         chk("c3_addr0", w_addr[0], 32'hFFF);
         chk("c3_data0", w_data[0], 32'h0403_0201);
         chk("c3_addr1", w_addr[1], 32'h000);
         chk("c3_data1", w_data[1], 32'h0807_0605);
      end
      wait_idle();

      // case 4: timeout after two bytes
      clear_log();
      blist = '{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      start_load(32'h040, 1);
      send_bytes(0, 2, 1'b0);
      begin
         int budget = 0;
         while (n_err == 0 && budget < 30) begin step(); budget++; end
         if (n_err == 0) bound_fail("c4_wait_error");
      end
      chk("c4_err_cyc", 32'(err_cyc), 32'(last_acc_cyc + 8));
      chk("c4_nwrites", 32'(w_addr.size()), 32'd0);
      step();
      chk("c4_busy_after", 32'(bus.load_busy), 32'd0);
      wait_idle();

      // case 5: toggling byte_valid, plus a load_start mid-load that must be ignored
      clear_log();
      blist = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      start_load(32'h010, 2);
      send_bytes(0, 4, 1'b1);
      start_load(32'h300, 0);
      send_bytes(4, 4, 1'b1);
      run(3);
      chk("c5_nwrites", 32'(w_addr.size()), 32'd2);
      if (w_addr.size() == 2) begin
         chk("c5_addr0", w_addr[0], 32'h010);
         chk("c5_data0", w_data[0], 32'h0000_0013);
         chk("c5_addr1", w_addr[1], 32'h011);
         chk("c5_data1", w_data[1], 32'h0010_0093);
      end
      chk("c5_ndone", 32'(n_done), 32'd1);
      wait_idle();

      // case 6: asynchronous reset mid-assemble, then passthrough and a fresh load
      clear_log();
      blist = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
      start_load(32'h050, 1);
      send_bytes(0, 2, 1'b0);
      #2 reset = 1'b1;
      bus.core_fetch_address = 32'h1234_5678;
      #1;
      chk("c6_rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      chk("c6_rst_core_stall", 32'(bus.core_stall), 32'd0);
      chk("c6_rst_load_busy", 32'(bus.load_busy), 32'd0);
      chk("c6_rst_addr", bus.instruction_memory_access_address, 32'h1234_5678);
      m_clear();
      step();
      reset = 1'b0;
      run(2);
      bus.core_fetch_address = 32'hDEAD_BEEF;
      #1;
      chk("c6_passthru", bus.instruction_memory_access_address, 32'hDEAD_BEEF);
      @(negedge clk);
      clear_log();
      start_load(32'h123, 1);
      send_bytes(0, 4, 1'b0);
      run(2);
      chk("c6_nwrites", 32'(w_addr.size()), 32'd1);
      if (w_addr.size() == 1) begin
         chk("c6_addr", w_addr[0], 32'h123);
         chk("c6_data", w_data[0], 32'h4433_2211);
      end
      chk("c6_ndone", 32'(n_done), 32'd1);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
